mdio_master: RTL and testbench
==============================

# mdio_master

Single-channel IEEE 802.3 Clause 22 management master that turns register read/write commands from the ethpipe control logic into MDC/MDIO frames for one Ethernet PHY. It runs on `clk_125` and sits between the ethpipe register block and the PHY management pins: one instance per PHY. The top level builds the `phyN_mii_data` tristate from `mdio_o` and `mdio_oe`, and feeds the pad back on `mdio_i`.

## Interface
- `CLK_DIV`, default 25: `clk_125` cycles per MDC half-period. Default gives 2.5 MHz MDC. Legal range 2..255.
- `clk_125` in 1: the block's only clock.
- `sys_rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high when idle. A command is accepted on `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_phy_addr` in 5: PHY address.
- `cmd_reg_addr` in 5: register address.
- `cmd_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 16: read data. Held until the next `rsp_valid`.
- `rsp_err` out 1: read turnaround error. Valid with `rsp_valid`.
- `mdc` out 1: management clock to the PHY.
- `mdio_o` out 1: MDIO output value.
- `mdio_oe` out 1: MDIO output enable. 1 = master drives the line.
- `mdio_i` in 1: MDIO pad input.

## Operation
- States: IDLE, PRE, HDR, TA, DATA, DONE.
- `cmd_ready` = (state == IDLE).
- When a command is accepted, all `cmd_*` fields are latched.
  - `cmd_*` changes after acceptance are ignored.
  - `cmd_valid` while busy is ignored.
- Frame layout, MSB first:
  - PRE: 32 ones.
  - HDR: 14 bits. ST = 01. OP = 01 for write, 10 for read. Then PHYAD[4:0], then REGAD[4:0].
  - TA: 2 bits. Write drives 1,0. Read releases the line (`mdio_oe` = 0) for both bits.
  - DATA: 16 bits. Write drives `cmd_wdata[15:0]`. Read releases the line and samples.
- Bit counter is 6 bits. It loads the segment length at each state entry and counts down to 0.
- Read sampling:
  - `mdio_i` is registered once. The registered value is sampled at the MDC rising tick of each bit.
  - TA bit 2 is sampled. `rsp_err` = 1 if the sample is 1 (PHY did not drive 0).
  - Read data is still captured when `rsp_err` = 1.
- DONE lasts one cycle and pulses `rsp_valid`. The next state is IDLE.
- Response values for a write: `rsp_rdata` = 0x0000, `rsp_err` = 0.
- Line control:
  - `mdio_oe` = 1 during PRE, HDR, and write TA/DATA.
  - `mdio_oe` = 0 otherwise. The external pull-up keeps the line idle high.
- Reset mid-frame:
  - The block returns to IDLE immediately and `mdc` goes to 0.
  - The line is released.
  - No `rsp_valid` is issued, and the latched command is discarded.

## Timing
- Reset values:
  - `mdc` = 0, `mdio_o` = 1, `mdio_oe` = 0.
  - `cmd_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- Each bit lasts 2×`CLK_DIV` cycles.
  - `mdc` is low for the first `CLK_DIV` cycles and high for the second.
  - The divider counter is 8 bits. It reloads at each half-period boundary and is held at 0 in IDLE.
- `mdio_o` and `mdio_oe` change only at a bit start, which is the MDC falling boundary.
  - This gives at least `CLK_DIV` cycles of setup before the rising edge and the same amount of hold after it.
- The first bit starts the cycle after acceptance.
  - `mdc` stays low for that bit's low phase.
  - `cmd_ready` is low from the cycle after acceptance.
- Frame length is 64 bits. With the default `CLK_DIV`, a frame is 3200 cycles.
- `rsp_valid` asserts one cycle after the last bit's high phase ends.
- `cmd_ready` reasserts the cycle after `rsp_valid`. The earliest next acceptance is that cycle.
- Outputs are registered, so there are no combinational paths from inputs to `mdc`/`mdio_*`.
- `mdc` is 0 whenever the block is idle.

## Configuration
- `MDIO_PREAMBLE_SUPPRESS_EN`
  - Defined: PRE is skipped, so HDR starts the cycle after acceptance. A frame is 32 bits (1600 cycles at the default `CLK_DIV`). Only for PHYs that support preamble suppression.
  - Undefined: the full 32-bit preamble precedes every frame.

## Test plan
- Write, `phy_addr` = 0x01, `reg_addr` = 0x00, `wdata` = 0x1140 -> MDIO bits on MDC rising edges are 32×1, 01, 01, 00001, 00000, 10, 0x1140. `rsp_valid` arrives 3201 cycles after acceptance with `rsp_err` = 0, `rsp_rdata` = 0x0000.
- Read, `phy_addr` = 0x07, `reg_addr` = 0x02, PHY model drives TA2 = 0 and data 0x0141 -> `mdio_oe` = 0 from TA start. `rsp_rdata` = 0x0141, `rsp_err` = 0.
- Read with no PHY (`mdio_i` stuck at 1) -> `rsp_err` = 1, `rsp_rdata` = 0xFFFF.
- Back-to-back: hold `cmd_valid` high for two commands -> the second is accepted exactly one cycle after the first `rsp_valid`. No MDC gap beyond that cycle. `cmd_*` changes during the first frame are not reflected in it.
- Assert `sys_rst` during HDR -> in the same cycle `mdc` = 0, `mdio_oe` = 0, `cmd_ready` = 1. No `rsp_valid`. After release, the next command produces a complete frame.
- With `MDIO_PREAMBLE_SUPPRESS_EN` defined, run a write -> the first MDC rising edge carries ST bit 0. `rsp_valid` arrives 1601 cycles after acceptance.

Source files
------------

// File: rtl/mdio_master.sv
// IEEE 802.3 Clause 22 MDIO master: one accepted command becomes one MDC/MDIO frame.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble.
module mdio_master #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk_125,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);
    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [31:0] sh_q, sh_d;
    logic        wr_q, wr_d;
    logic        mdc_q, mdc_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        mdio_in_q;
    logic [15:0] rx_q, rx_d;
    logic        ta_err_q, ta_err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] frame;
    logic        tick;
    logic        drive;

    // Everything after the preamble; read frames carry ones where the PHY owns the line.
    assign frame = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                    cmd_write ? {2'b10, cmd_wdata} : 18'h3FFFF};
    assign tick  = (div_q == 8'd0);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        wr_d      = wr_q;
        mdc_d     = mdc_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        rx_d      = rx_q;
        ta_err_d  = ta_err_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        drive     = 1'b0;

        case (state_q)
            IDLE: begin
                div_d     = 8'd0;
                mdc_d     = 1'b0;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b0;
                if (cmd_valid) begin
                    wr_d      = cmd_write;
                    div_d     = DIV_LOAD;
                    mdio_oe_d = 1'b1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                    state_d   = HDR;
                    bit_d     = 6'd13;
                    mdio_o_d  = frame[31];
                    sh_d      = {frame[30:0], 1'b0};
`else
                    state_d   = PRE;
                    bit_d     = 6'd31;
                    mdio_o_d  = 1'b1;
                    sh_d      = frame;
`endif
                end
            end
            PRE, HDR, TA, DATA: begin
                if (!tick) begin
                    div_d = div_q - 8'd1;
                end else if (!mdc_q) begin
                    // Rising MDC tick: the PHY's bit has had a full low phase to settle.
                    mdc_d = 1'b1;
                    div_d = DIV_LOAD;
                    if (state_q == TA && bit_q == 6'd0) begin
                        ta_err_d = mdio_in_q;
                    end
                    if (state_q == DATA) begin
                        rx_d = {rx_q[14:0], mdio_in_q};
                    end
                end else begin
                    mdc_d = 1'b0;
                    div_d = DIV_LOAD;
                    if (bit_q != 6'd0) begin
                        bit_d = bit_q - 6'd1;
                    end else begin
                        case (state_q)
                            PRE:     begin state_d = HDR;  bit_d = 6'd13; end
                            HDR:     begin state_d = TA;   bit_d = 6'd1;  end
                            TA:      begin state_d = DATA; bit_d = 6'd15; end
                            default: begin state_d = DONE; bit_d = 6'd0;  end
                        endcase
                    end

                    if (state_d == PRE) begin
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b1;
                    end else if (state_d == DONE) begin
                        div_d     = 8'd0;
                        mdio_o_d  = 1'b1;
                        mdio_oe_d = 1'b0;
                        rdata_d   = wr_q ? 16'h0000 : rx_q;
                        err_d     = !wr_q && ta_err_q;
                    end else begin
                        drive     = (state_d == HDR) || wr_q;
                        mdio_oe_d = drive;
                        mdio_o_d  = drive ? sh_q[31] : 1'b1;
                        sh_d      = {sh_q[30:0], 1'b0};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_125 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_q     <= 6'd0;
            sh_q      <= 32'd0;
            wr_q      <= 1'b0;
            mdc_q     <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            mdio_in_q <= 1'b1;
            rx_q      <= 16'd0;
            ta_err_q  <= 1'b0;
            rdata_q   <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            wr_q      <= wr_d;
            mdc_q     <= mdc_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
            mdio_in_q <= mdio_i;
            rx_q      <= rx_d;
            ta_err_q  <= ta_err_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: cycle-level frame model plus directed literal checks.
// Builds with or without MDIO_PREAMBLE_SUPPRESS_EN.
module tb_mdio_master;
    localparam int DIV = 25;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int PRE_BITS = 0;
    localparam int EXP_LAT  = 1601;
`else
    localparam int PRE_BITS = 32;
    localparam int EXP_LAT  = 3201;
`endif
    localparam int NBITS     = PRE_BITS + 32;
    localparam int FRAME_CYC = NBITS * 2 * DIV;
    localparam int RST_T     = (PRE_BITS + 4) * 2 * DIV + DIV + 4;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;

    int errors = 0;
    int checks = 0;
    int rv_count = 0;

    mdio_master #(.CLK_DIV(DIV)) dut (
        .clk_125      (clk),
        .sys_rst      (sys_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_phy_addr (cmd_phy_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .mdio_i       (mdio_i)
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: which command is in flight and how many cycles since acceptance.
    logic        m_busy = 1'b0;
    int          m_t = 0;
    logic        m_wr = 1'b0;
    logic [4:0]  m_pa = 5'd0;
    logic [4:0]  m_ra = 5'd0;
    logic [15:0] m_wd = 16'd0;
    logic [15:0] m_rdata = 16'd0;
    logic        m_err = 1'b0;
    logic        phy_present = 1'b1;
    logic [15:0] phy_data = 16'd0;

    function automatic logic exp_bit(input int b, input logic wr, input logic [4:0] pa,
                                     input logic [4:0] ra, input logic [15:0] wd);
        logic [31:0] w;
        w = {2'b01, wr ? 2'b01 : 2'b10, pa, ra, 2'b10, wd};
        if (b < PRE_BITS) return 1'b1;
        return w[31 - (b - PRE_BITS)];
    endfunction

    function automatic logic exp_oe(input int b, input logic wr);
        return (b < PRE_BITS + 14) || wr;
    endfunction

    function automatic logic phy_drive(input int b);
        if (b == PRE_BITS + 15) return 1'b0;
        if (b >= PRE_BITS + 16 && b < NBITS) return phy_data[15 - (b - PRE_BITS - 16)];
        return 1'b1;
    endfunction

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_busy  <= 1'b0;
            m_t     <= 0;
            m_rdata <= 16'd0;
            m_err   <= 1'b0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy <= 1'b1;
                m_t    <= 1;
                m_wr   <= cmd_write;
                m_pa   <= cmd_phy_addr;
                m_ra   <= cmd_reg_addr;
                m_wd   <= cmd_wdata;
            end
        end else if (m_t == FRAME_CYC + 1) begin
            m_busy <= 1'b0;
            m_t    <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == FRAME_CYC) begin
                m_rdata <= m_wr ? 16'h0000 : (phy_present ? phy_data : 16'hFFFF);
                m_err   <= !m_wr && !phy_present;
            end
        end
    end

    // Per-cycle compare against the model, and the PHY driving mdio_i for reads.
    always @(negedge clk) begin : cmp
        int   b;
        logic e_mdc, e_oe, e_o, e_rv, phy_v;
        b = 0; e_mdc = 1'b0; e_oe = 1'b0; e_o = 1'b1; e_rv = 1'b0; phy_v = 1'b1;
        if (m_busy && m_t <= FRAME_CYC) begin
            b     = (m_t - 1) / (2 * DIV);
            e_mdc = ((m_t - 1) % (2 * DIV)) >= DIV;
            e_oe  = exp_oe(b, m_wr);
            e_o   = exp_bit(b, m_wr, m_pa, m_ra, m_wd);
            if (!m_wr && phy_present) phy_v = phy_drive(b);
        end else if (m_busy) begin
            e_rv = 1'b1;
        end
        chk("mdc", 32'(mdc), 32'(e_mdc));
        chk("mdio_oe", 32'(mdio_oe), 32'(e_oe));
        if (e_oe) chk("mdio_o", 32'(mdio_o), 32'(e_o));
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        if (e_rv) chk("rsp_err", 32'(rsp_err), 32'(m_err));
        if (rsp_valid) rv_count <= rv_count + 1;
        mdio_i = phy_v;
    end

    logic [63:0] cap = 64'd0;
    logic [63:0] capoe = 64'd0;
    always @(posedge mdc) begin
        cap   <= {cap[62:0], mdio_o};
        capoe <= {capoe[62:0], mdio_oe};
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20000) begin @(negedge clk); lat++; end
    endtask

    task automatic do_cmd(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, output int lat);
        cmd_write = wr; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = wd;
        cmd_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int rv_before;
        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_phy_addr = 5'd0; cmd_reg_addr = 5'd0; cmd_wdata = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_mdc", 32'(mdc), 32'd0);
        chk("rst_mdio_o", 32'(mdio_o), 32'd1);
        chk("rst_mdio_oe", 32'(mdio_oe), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        sys_rst = 1'b0;
        @(negedge clk);

        do_cmd(1'b1, 5'h01, 5'h00, 16'h1140, lat);
        $display("write phy=01 reg=00 wdata=1140 lat=%0d rdata=%h err=%0d", lat, rsp_rdata, rsp_err);
        chk("wr_latency", 32'(lat), 32'(EXP_LAT));
`ifndef MDIO_PREAMBLE_SUPPRESS_EN
        chk("wr_preamble", cap[63:32], 32'hFFFFFFFF);
`endif
        chk("wr_frame", cap[31:0], 32'h50821140);
        chk("wr_oe", capoe[31:0], 32'hFFFFFFFF);
        chk("wr_rdata", 32'(rsp_rdata), 32'h0000);
        chk("wr_err", 32'(rsp_err), 32'd0);

        phy_present = 1'b1; phy_data = 16'h0141;
        do_cmd(1'b0, 5'h07, 5'h02, 16'hDEAD, lat);
        $display("read phy=07 reg=02 lat=%0d rdata=%h err=%0d", lat, rsp_rdata, rsp_err);
        chk("rd_latency", 32'(lat), 32'(EXP_LAT));
        chk("rd_header", 32'(cap[31:18]), 32'(14'b01100011100010));
        chk("rd_oe", capoe[31:0], 32'hFFFC0000);
        chk("rd_rdata", 32'(rsp_rdata), 32'h0141);
        chk("rd_err", 32'(rsp_err), 32'd0);

        phy_present = 1'b0;
        do_cmd(1'b0, 5'h03, 5'h01, 16'h0000, lat);
        $display("read no-phy lat=%0d rdata=%h err=%0d", lat, rsp_rdata, rsp_err);
        chk("nophy_rdata", 32'(rsp_rdata), 32'hFFFF);
        chk("nophy_err", 32'(rsp_err), 32'd1);

        // Back-to-back: valid stays high, fields switch to the second command mid-frame.
        phy_present = 1'b1; phy_data = 16'h1234;
        @(negedge clk);
        cmd_write = 1'b1; cmd_phy_addr = 5'h03; cmd_reg_addr = 5'h04; cmd_wdata = 16'hBEEF;
        cmd_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        cmd_write = 1'b0; cmd_phy_addr = 5'h05; cmd_reg_addr = 5'h06; cmd_wdata = 16'h0F0F;
        wait_rsp(lat);
        $display("b2b first write lat=%0d rdata=%h", lat, rsp_rdata);
        chk("b2b_first_frame", cap[31:0], 32'h5192BEEF);
        chk("b2b_first_rdata", 32'(rsp_rdata), 32'h0000);
        chk("b2b_ready_at_rsp", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready_after", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("b2b_second_accepted", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        wait_rsp(lat);
        $display("b2b second read lat=%0d rdata=%h err=%0d", lat, rsp_rdata, rsp_err);
        chk("b2b_second_latency", 32'(lat), 32'(EXP_LAT));
        chk("b2b_second_rdata", 32'(rsp_rdata), 32'h1234);

        // Reset in the middle of HDR, during an MDC high phase.
        @(negedge clk);
        phy_data = 16'h0141;
        cmd_write = 1'b0; cmd_phy_addr = 5'h07; cmd_reg_addr = 5'h02; cmd_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (n < RST_T) begin @(negedge clk); n++; end
        chk("pre_rst_mdc", 32'(mdc), 32'd1);
        rv_before = rv_count;
        @(posedge clk);
        #2 sys_rst = 1'b1;
        #1;
        $display("reset in HDR mdc=%0d oe=%0d ready=%0d", mdc, mdio_oe, cmd_ready);
        chk("rst_mid_mdc", 32'(mdc), 32'd0);
        chk("rst_mid_oe", 32'(mdio_oe), 32'd0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("rst_no_rsp", 32'(rv_count), 32'(rv_before));

        do_cmd(1'b1, 5'h1F, 5'h1F, 16'hA5C3, lat);
        $display("write after reset lat=%0d rdata=%h err=%0d", lat, rsp_rdata, rsp_err);
        chk("post_rst_latency", 32'(lat), 32'(EXP_LAT));
        chk("post_rst_frame", cap[31:0], 32'h5FFEA5C3);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
